// File: rtl/sbox_pipe.sv
// Pipelined AES SubBytes/InvSubBytes over LANES independent byte lanes.
// The lookup is done before the first register; the remaining stages only delay.
module sbox_pipe #(
    parameter int LANES       = 4,
    parameter int PIPE_STAGES = 2,
    parameter bit ENABLE_INV  = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    input  logic               in_inv,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data,
    output logic               out_inv,
    output logic               busy
);
    localparam int W    = 8 * LANES;
    localparam int LAST = PIPE_STAGES - 1;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
        logic [7:0] i;
        i = gf_inv(b);
        return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] b);
        return gf_inv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
    endfunction

    logic [W-1:0] sub_d;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [7:0] lane_b;
        assign lane_b = in_data[8*g +: 8];
        if (ENABLE_INV) begin : g_inv
            assign sub_d[8*g +: 8] = in_inv ? sbox_inv(lane_b) : sbox_fwd(lane_b);
        end else begin : g_fwd
            assign sub_d[8*g +: 8] = sbox_fwd(lane_b);
        end
    end

    logic [PIPE_STAGES-1:0] valid_q;
    logic [PIPE_STAGES-1:0] valid_d;
    logic [PIPE_STAGES-1:0] inv_q;
    logic [W-1:0]           data_q [PIPE_STAGES];
    logic                   busy_q;

    logic [PIPE_STAGES-1:0] ld;
    logic [PIPE_STAGES-1:0] src_valid;
    logic [PIPE_STAGES-1:0] src_inv;
    logic [W-1:0]           src_data [PIPE_STAGES];
    logic                   room;

    // A stage may load when any slot from it to the output is free, or the output drains.
    always_comb begin
        room = out_ready;
        ld   = '0;
        for (int k = LAST; k >= 0; k--) begin
            room  = room | ~valid_q[k];
            ld[k] = room;
        end
        src_valid[0] = in_valid;
        src_inv[0]   = in_inv;
        src_data[0]  = sub_d;
        for (int k = 1; k < PIPE_STAGES; k++) begin
            src_valid[k] = valid_q[k-1];
            src_inv[k]   = inv_q[k-1];
            src_data[k]  = data_q[k-1];
        end
        for (int k = 0; k < PIPE_STAGES; k++) begin
            valid_d[k] = ld[k] ? src_valid[k] : valid_q[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            inv_q   <= '0;
            busy_q  <= 1'b0;
            for (int k = 0; k < PIPE_STAGES; k++) data_q[k] <= '0;
        end else begin
            valid_q <= valid_d;
            busy_q  <= |valid_d;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                if (ld[k] && src_valid[k]) begin
                    data_q[k] <= src_data[k];
                    inv_q[k]  <= src_inv[k];
                end
            end
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = valid_q[LAST];
    assign out_data  = data_q[LAST];
    assign out_inv   = inv_q[LAST];
    assign busy      = busy_q;

endmodule

// File: tb/tb_sbox_pipe.sv
// Bench for sbox_pipe: directed and random transfers scored against table-driven
// AES S-box model; a forward-only build runs in lockstep beside the main one.
module tb_sbox_pipe;
    localparam int LANES = 4;
    localparam int PS    = 2;
    localparam int W     = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_inv;
    logic         out_ready;
    logic [W-1:0] in_data;
    logic         in_ready, out_valid, out_inv, busy;
    logic [W-1:0] out_data;
    logic         f_in_ready, f_out_valid, f_out_inv, f_busy;
    logic [W-1:0] f_out_data;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [W-1:0] d;
        logic         inv;
    } xfer_t;

    xfer_t        sbq[$];
    logic [W-1:0] cap_q[$];
    logic [W-1:0] fw_q[$];
    logic         stall_prev;
    logic [W-1:0] hold_data;
    logic         hold_inv;

    logic [7:0] fwd_tbl [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };
    logic [7:0] inv_tbl [256];

    sbox_pipe #(.LANES(LANES), .PIPE_STAGES(PS), .ENABLE_INV(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_inv(in_inv),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_inv(out_inv),
        .busy(busy)
    );

    sbox_pipe #(.LANES(LANES), .PIPE_STAGES(PS), .ENABLE_INV(1'b0)) dut_f (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(f_in_ready), .in_data(in_data), .in_inv(in_inv),
        .out_valid(f_out_valid), .out_ready(out_ready), .out_data(f_out_data), .out_inv(f_out_inv),
        .busy(f_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] ref_sub(input logic [W-1:0] d, input logic inv, input bit en);
        logic [W-1:0] r;
        r = '0;
        for (int l = 0; l < LANES; l++)
            r[8*l +: 8] = (inv && en) ? inv_tbl[d[8*l +: 8]] : fwd_tbl[d[8*l +: 8]];
        return r;
    endfunction

    function automatic logic [W-1:0] lane_pattern(input int v);
        return {8'(v + 3), 8'(v + 2), 8'(v + 1), 8'(v)};
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: score both handshakes at the falling edge, return just after the rising edge.
    task automatic tick(output bit acc);
        xfer_t x;
        @(negedge clk);
        acc = in_valid && in_ready;
        chk("in_ready", 32'(in_ready), 32'((sbq.size() < PS) || out_ready));
        chk("busy", 32'(busy), 32'(sbq.size() != 0));
        chk("f_in_ready", 32'(f_in_ready), 32'(in_ready));
        chk("f_out_valid", 32'(f_out_valid), 32'(out_valid));
        if (stall_prev) begin
            chk("stall_data", out_data, hold_data);
            chk("stall_inv", 32'(out_inv), 32'(hold_inv));
        end
        stall_prev = out_valid && !out_ready;
        hold_data  = out_data;
        hold_inv   = out_inv;
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                x = sbq.pop_front();
                chk("out_data", out_data, ref_sub(x.d, x.inv, 1'b1));
                chk("out_inv", 32'(out_inv), 32'(x.inv));
                chk("f_out_data", f_out_data, ref_sub(x.d, x.inv, 1'b0));
                chk("f_out_inv", 32'(f_out_inv), 32'(x.inv));
                cap_q.push_back(out_data);
            end
        end
        if (acc) begin
            x.d   = in_data;
            x.inv = in_inv;
            sbq.push_back(x);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [W-1:0] d, input logic inv);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_inv   = inv;
        for (int i = 0; i < 20 && !acc; i++) tick(acc);
        chk("accept_timeout", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        bit acc;
        for (int i = 0; i < 20 && !out_valid; i++) tick(acc);
        chk("out_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_out_data"}, out_data, 32'd0);
        chk({tag, "_out_inv"}, 32'(out_inv), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        bit acc;
        int n_acc;

        for (int i = 0; i < 256; i++) inv_tbl[fwd_tbl[i]] = 8'(i);
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_inv     = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        stall_prev = 1'b0;
        hold_data  = '0;
        hold_inv   = 1'b0;

        #2;
        check_reset_values("rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) tick(acc);

        // Forward stream: latency and back-to-back outputs
        send_one(32'h000153ff, 1'b0);
        chk("lat_early", 32'(out_valid), 32'd0);
        send_one(32'h10203040, 1'b0);
        chk("lat_first_valid", 32'(out_valid), 32'd1);
        chk("fwd_first", out_data, 32'h637ced16);
        tick(acc);
        chk("fwd_second_valid", 32'(out_valid), 32'd1);
        chk("fwd_second", out_data, 32'hcab70409);
        repeat (2) tick(acc);

        // Inverse and mixed mode
        send_one(32'h637ced16, 1'b1);
        send_one(32'h00000000, 1'b0);
        wait_out();
        chk("inv_data", out_data, 32'h000153ff);
        chk("inv_flag", 32'(out_inv), 32'd1);
        tick(acc);
        wait_out();
        chk("mix_data", out_data, 32'h63636363);
        chk("mix_flag", 32'(out_inv), 32'd0);
        tick(acc);

        // Forward-only build ignores in_inv but echoes it
        send_one(32'h63636363, 1'b1);
        wait_out();
        chk("noinv_data", f_out_data, 32'hfbfbfbfb);
        chk("noinv_flag", 32'(f_out_inv), 32'd1);
        chk("inv_build_data", out_data, 32'h00000000);
        repeat (2) tick(acc);

        // Back-pressure: pipe fills exactly PS deep, then drains one per cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        n_acc     = 0;
        for (int i = 0; i < 6; i++) begin
            in_data = $urandom;
            in_inv  = 1'($urandom_range(0, 1));
            tick(acc);
            n_acc += int'(acc);
        end
        chk("bp_accepted", n_acc, PS);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < PS; i++) begin
            chk("bp_drain_valid", 32'(out_valid), 32'd1);
            tick(acc);
        end
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Every byte value in every lane, forward at full rate, then fed back inverse
        cap_q.delete();
        n_acc = 0;
        for (int v = 0; v < 256; v++) begin
            in_valid = 1'b1;
            in_data  = lane_pattern(v);
            in_inv   = 1'b0;
            tick(acc);
            n_acc += int'(acc);
        end
        in_valid = 1'b0;
        repeat (PS + 1) tick(acc);
        chk("rt_fwd_rate", n_acc, 256);
        chk("rt_fwd_count", cap_q.size(), 256);
        fw_q = cap_q;
        cap_q.delete();
        for (int v = 0; v < 256; v++) begin
            in_valid = 1'b1;
            in_data  = (v < fw_q.size()) ? fw_q[v] : '0;
            in_inv   = 1'b1;
            tick(acc);
        end
        in_valid = 1'b0;
        repeat (PS + 1) tick(acc);
        chk("rt_inv_count", cap_q.size(), 256);
        for (int v = 0; v < 256 && v < cap_q.size(); v++)
            chk("rt_roundtrip", cap_q[v], lane_pattern(v));

        // Random traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            in_inv    = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            tick(acc);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (PS + 2) tick(acc);
        chk("rand_drained", sbq.size(), 0);

        // Reset mid-stream with two transfers in flight
        out_ready = 1'b0;
        send_one($urandom, 1'b0);
        send_one($urandom, 1'b1);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        sbq.delete();
        stall_prev = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(acc);
            chk("post_rst_idle", 32'(out_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
